// File: rtl/fdiv.sv
// fdiv: iterative IEEE-754 single-precision divider.
// Restoring radix-2 mantissa division, one quotient bit per cycle,
// with round-to-nearest-even and flush-to-zero on underflow.
module fdiv #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] c_o
);

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        DIVIDE,
        ROUND,
        DONE
    } state_t;

    localparam logic [1:0] SP_NONE = 2'd0;
    localparam logic [1:0] SP_NAN  = 2'd1;
    localparam logic [1:0] SP_INF  = 2'd2;
    localparam logic [1:0] SP_ZERO = 2'd3;

    localparam logic [4:0] LAST_ITER = 5'd24;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] a_q, b_q, c_q;
    logic                  sign_q;
    logic [9:0]            exp_q;
    logic [24:0]           rem_q;
    logic [23:0]           mb_q;
    logic [23:0]           quot_q;
    logic [4:0]            count_q;
    logic [1:0]            special_q;

    // Unpacking and classification of the latched operands
    logic [7:0]  ea, eb;
    logic [22:0] fa, fb;
    logic [23:0] ma, mb;
    logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic        a_lt_b;
    logic [9:0]  exp_prep;
    logic [1:0]  special_prep;

    // Divide step and rounding signals
    logic        ge;
    logic [24:0] rem_sel;
    logic        sticky, round_up, carry;
    logic [23:0] frac_r;
    logic [9:0]  exp_r;
    logic [31:0] result_round;

    assign ready_o = (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign c_o     = c_q;

    // Unpack operands with the hidden bit, classify specials and
    // pre-normalise so the quotient always lands in [1, 2)
    always_comb begin
        ea     = a_q[30:23];
        eb     = b_q[30:23];
        fa     = a_q[22:0];
        fb     = b_q[22:0];
        ma     = {(ea != 8'd0), fa};
        mb     = {(eb != 8'd0), fb};
        a_zero = (ea == 8'd0);
        b_zero = (eb == 8'd0);
        a_inf  = (ea == 8'hFF) && (fa == 23'd0);
        b_inf  = (eb == 8'hFF) && (fb == 23'd0);
        a_nan  = (ea == 8'hFF) && (fa != 23'd0);
        b_nan  = (eb == 8'hFF) && (fb != 23'd0);
        a_lt_b = (ma < mb);
        exp_prep = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, a_lt_b};
        special_prep = SP_NONE;
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            special_prep = SP_NAN;
        end else if (a_inf || b_zero) begin
            special_prep = SP_INF;
        end else if (a_zero || b_inf) begin
            special_prep = SP_ZERO;
        end
    end

    // Restoring step: subtract the divisor when it fits
    always_comb begin
        ge      = (rem_q >= {1'b0, mb_q});
        rem_sel = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
    end

    // Round to nearest even, then apply range limits and special overrides
    always_comb begin
        sticky   = (rem_q != 25'd0);
        round_up = quot_q[0] & (sticky | quot_q[1]);
        frac_r   = {1'b0, quot_q[23:1]} + {23'd0, round_up};
        carry    = frac_r[23];
        exp_r    = exp_q + {9'd0, carry};
        result_round = {sign_q, exp_r[7:0], frac_r[22:0]};
        case (special_q)
            SP_NAN:  result_round = 32'h7FC0_0000;
            SP_INF:  result_round = {sign_q, 8'hFF, 23'd0};
            SP_ZERO: result_round = {sign_q, 31'd0};
            default: begin
                if ($signed(exp_r) >= 10'sd255) begin
                    result_round = {sign_q, 8'hFF, 23'd0};
                end else if ($signed(exp_r) <= 10'sd0) begin
                    result_round = {sign_q, 31'd0};
                end
            end
        endcase
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Fixed schedule: PREP 1, DIVIDE 25, ROUND 1, then hold in DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (valid_i) state_d = PREP;
            PREP:    state_d = DIVIDE;
            DIVIDE:  if (count_q == LAST_ITER) state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath registers; c_o only changes when a result is rounded
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            sign_q    <= 1'b0;
            exp_q     <= '0;
            rem_q     <= '0;
            mb_q      <= '0;
            quot_q    <= '0;
            count_q   <= '0;
            special_q <= SP_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        a_q <= a_i;
                        b_q <= b_i;
                    end
                end
                PREP: begin
                    sign_q    <= a_q[31] ^ b_q[31];
                    exp_q     <= exp_prep;
                    rem_q     <= a_lt_b ? {ma, 1'b0} : {1'b0, ma};
                    mb_q      <= mb;
                    quot_q    <= '0;
                    count_q   <= '0;
                    special_q <= special_prep;
                end
                DIVIDE: begin
                    rem_q   <= rem_sel << 1;
                    quot_q  <= (quot_q << 1) | {23'd0, ge};
                    count_q <= count_q + 5'd1;
                end
                ROUND: begin
                    c_q <= result_round;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fdiv.sv
// tb_fdiv: directed-vector bench for the iterative divider.
module tb_fdiv;

    logic        clk_i;
    logic        rst_ni;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] c_o;

    int vectors;
    int miscompares;

    fdiv #(.DATA_WIDTH(32)) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .a_i     (a_i),
        .b_i     (b_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .c_o     (c_o)
    );

    // 100 MHz clock
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // Issue one divide at a negedge, time it, optionally stall the result,
    // then release it and confirm the return to IDLE.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expected,
                                 input int hold);
        int edges;
        logic [31:0] held;
        checkOutput({tag, "_ready_in"}, {31'd0, ready_o}, 32'd1);
        valid_i = 1'b1;
        a_i     = a;
        b_i     = b;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        a_i     = 32'hDEAD_BEEF;
        b_i     = 32'h1234_5678;
        checkOutput({tag, "_busy"}, {31'd0, ready_o}, 32'd0);
        edges = 1;
        while (!valid_o && edges < 100) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (!valid_o) edges++;
        end
        checkOutput({tag, "_latency"}, 32'(edges), 32'd27);
        checkOutput({tag, "_c"}, c_o, expected);
        held = c_o;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            checkOutput({tag, "_hold_c"}, c_o, held);
            checkOutput({tag, "_hold_valid"}, {31'd0, valid_o}, 32'd1);
            checkOutput({tag, "_hold_ready"}, {31'd0, ready_o}, 32'd0);
        end
        ready_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        ready_i = 1'b0;
        checkOutput({tag, "_exit_valid"}, {31'd0, valid_o}, 32'd0);
        checkOutput({tag, "_exit_c"}, c_o, expected);
    endtask

    // Main sequence
    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_ni  = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        #12;
        checkOutput("rst_ready", {31'd0, ready_o}, 32'd1);
        checkOutput("rst_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("rst_c", c_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        applyStimulus("six_by_two", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0);
        applyStimulus("one_by_one", 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 0);
        applyStimulus("three_by_two", 32'h4040_0000, 32'h4000_0000, 32'h3FC0_0000, 0);
        applyStimulus("one_by_three", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0);
        applyStimulus("neg_one_by_two", 32'hBF80_0000, 32'h4000_0000, 32'hBF00_0000, 0);
        applyStimulus("one_by_zero", 32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 0);
        applyStimulus("neg_by_zero", 32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 0);
        applyStimulus("zero_by_zero", 32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 0);
        applyStimulus("zero_by_two", 32'h0000_0000, 32'h4000_0000, 32'h0000_0000, 0);
        applyStimulus("nan_by_one", 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 0);
        applyStimulus("inf_by_inf", 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 0);
        applyStimulus("inf_by_two", 32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 0);
        applyStimulus("two_by_inf", 32'h4000_0000, 32'h7F80_0000, 32'h0000_0000, 0);
        applyStimulus("overflow", 32'h7F7F_FFFF, 32'h0080_0000, 32'h7F80_0000, 0);
        applyStimulus("underflow", 32'h0080_0000, 32'h7F7F_FFFF, 32'h0000_0000, 0);
        applyStimulus("subnormal_in", 32'h0000_0001, 32'h3F80_0000, 32'h0000_0000, 0);

        applyStimulus("stall", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 5);
        applyStimulus("back_to_back", 32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 0);

        valid_i = 1'b1;
        a_i     = 32'h3F80_0000;
        b_i     = 32'h4000_0000;
        @(posedge clk_i);
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("abort_valid", {31'd0, valid_o}, 32'd0);
        checkOutput("abort_c", c_o, 32'd0);
        checkOutput("abort_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        applyStimulus("after_abort", 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
